// File: rtl/textdisp_console.sv
// Console sequencer for the text display: buffers PUTC/SETXY/CLEAR commands,
// tracks the cursor and emits one registered character write per cycle.
module textdisp_console #(
  parameter int COLS       = 32,
  parameter int ROWS       = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        wclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [3:0]  char_we,
  output logic [31:0] char_di,
  output logic [4:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0] XMAX = 5'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  localparam logic [1:0] OP_PUTC  = 2'd0;
  localparam logic [1:0] OP_SETXY = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic        full, empty, push, pop;
  logic [1:0]  h_op;
  logic [15:0] h_data;
  logic [7:0]  h_ch;
  logic        unused_hi;

  logic        we_q, we_d;
  logic [31:0] di_q, di_d;
  logic [4:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic [4:0]  fx_q, fx_d;
  logic [4:0]  fy_q, fy_d;
  logic [6:0]  fch_q, fch_d;

  function automatic logic [4:0] y_inc(input logic [4:0] y);
    return (y == YMAX) ? 5'd0 : y + 5'd1;
  endfunction

  function automatic logic [31:0] pack(
    input logic [4:0] x,
    input logic [4:0] y,
    input logic [6:0] ch
  );
    return {11'b0, x, 3'b0, y, 1'b0, ch};
  endfunction

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == S_IDLE) && !empty;

  assign {h_op, h_data} = mem_q[rp_q];
  assign h_ch      = h_data[7:0];
  assign unused_hi = ^h_data[15:13];

  always_ff @(posedge wclk) begin
    if (push) mem_q[wp_q] <= {cmd_op, cmd_data};
  end

  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    di_d    = di_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fch_d   = fch_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          unique case (h_op)
            OP_PUTC: begin
              if (h_ch == 8'h0A) begin
                cx_d = 5'd0;
                cy_d = y_inc(cy_q);
              end else if (h_ch == 8'h0D) begin
                cx_d = 5'd0;
              end else if (h_ch == 8'h08) begin
                if (cx_q != 5'd0) cx_d = cx_q - 5'd1;
              end else if (h_ch >= 8'h20) begin
                we_d = 1'b1;
                // non-ASCII bytes show as '?'
                di_d = pack(cx_q, cy_q, h_ch[7] ? 7'h3F : h_ch[6:0]);
                if (cx_q == XMAX) begin
                  cx_d = 5'd0;
                  cy_d = y_inc(cy_q);
                end else begin
                  cx_d = cx_q + 5'd1;
                end
              end
            end
            OP_SETXY: begin
              cx_d = (h_data[4:0] > XMAX) ? XMAX : h_data[4:0];
              cy_d = (h_data[12:8] > YMAX) ? YMAX : h_data[12:8];
            end
            OP_CLEAR: begin
              fch_d   = h_data[6:0];
              fx_d    = 5'd0;
              fy_d    = 5'd0;
              state_d = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        we_d = 1'b1;
        di_d = pack(fx_q, fy_q, fch_q);
        if (fx_q == XMAX) begin
          fx_d = 5'd0;
          if (fy_q == YMAX) begin
            fy_d    = 5'd0;
            cx_d    = 5'd0;
            cy_d    = 5'd0;
            state_d = S_IDLE;
          end else begin
            fy_d = fy_q + 5'd1;
          end
        end else begin
          fx_d = fx_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      fch_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      di_q    <= di_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fch_q   <= fch_d;
    end
  end

  assign char_we  = {4{we_q}};
  assign char_di  = di_q;
  assign cursor_x = cx_q;
  assign cursor_y = cy_q;
  assign busy     = !empty || (state_q != S_IDLE) || we_q;

endmodule

// File: tb/tb_textdisp_console.sv
// Bench for textdisp_console: a terminal model predicts the write stream
// and cursor; directed tests pin latency, wrap, clamping, fill and reset.
module tb_textdisp_console;

  localparam int COLS  = 32;
  localparam int ROWS  = 28;
  localparam int NCELL = COLS * ROWS;

  logic        wclk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [3:0]  char_we;
  logic [31:0] char_di;
  logic [4:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  textdisp_console #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(8)) dut (
    .wclk(wclk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .char_we(char_we),
    .char_di(char_di),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .busy(busy)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_wr = 0;
  logic [31:0] last_di = '0;
  logic [31:0] exp_q[$];
  int mx = 0;
  int my = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int c);
    return 32'((x << 16) | (y << 8) | c);
  endfunction

  // terminal semantics applied to each accepted command
  function automatic void model_cmd(input logic [1:0] op,
                                    input logic [15:0] d);
    int c;
    c = int'(d[7:0]);
    case (op)
      2'd0: begin
        if (c == 10) begin
          mx = 0;
          my = (my + 1) % ROWS;
        end else if (c == 13) begin
          mx = 0;
        end else if (c == 8) begin
          if (mx > 0) mx--;
        end else if (c >= 32) begin
          exp_q.push_back(mk(mx, my, (c >= 128) ? 63 : c));
          mx++;
          if (mx == COLS) begin
            mx = 0;
            my = (my + 1) % ROWS;
          end
        end
      end
      2'd1: begin
        mx = int'(d[4:0]);
        if (mx > COLS - 1) mx = COLS - 1;
        my = int'(d[12:8]);
        if (my > ROWS - 1) my = ROWS - 1;
      end
      2'd2: begin
        for (int i = 0; i < NCELL; i++)
          exp_q.push_back(mk(i % COLS, i / COLS, int'(d[6:0])));
        mx = 0;
        my = 0;
      end
      default: ;
    endcase
  endfunction

  always @(negedge wclk) begin
    if (reset) begin
      exp_q.delete();
      mx = 0;
      my = 0;
    end else begin
      if (char_we !== 4'h0) begin
        n_wr++;
        last_di = char_di;
        chk("we_level", 32'(char_we), 32'hF);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%08h want none", char_di);
        end else begin
          chk("write", char_di, exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) model_cmd(cmd_op, cmd_data);
    end
  end

  task automatic push(input logic [1:0] op, input logic [15:0] d,
                      output int waited);
    waited = 0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge wclk);
      if (cmd_ready) begin
        @(posedge wclk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
      waited++;
      @(posedge wclk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL push_timeout: got no ready want ready");
    cmd_valid = 1'b0;
  endtask

  task automatic put(input logic [1:0] op, input logic [15:0] d);
    int w;
    push(op, d, w);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 3000; k++) begin
      @(negedge wclk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_cursor"}, {cursor_y, cursor_x}, 32'((my << 5) | mx));
    @(posedge wclk);
    #1;
  endtask

  initial begin
    int w;
    int wsum;
    int run;
    int cnt;
    int w0;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = '0;
    #12;
    chk("rst_we", 32'(char_we), 32'd0);
    chk("rst_di", char_di, 32'd0);
    chk("rst_cursor", {cursor_y, cursor_x}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge wclk);
    #1;
    reset = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    put(2'd0, 16'h0041);
    @(negedge wclk);
    chk("putc_pop_cycle_we", 32'(char_we), 32'd0);
    @(negedge wclk);
    chk("putc_we", 32'(char_we), 32'hF);
    chk("putc_di", char_di, 32'h0000_0041);
    chk("putc_cursor", {cursor_y, cursor_x}, {5'd0, 5'd1});
    wait_idle("t1");

    put(2'd1, 16'h1B1F);
    put(2'd0, 16'h005A);
    wait_idle("t2");
    chk("wrap_di", last_di, 32'h001F_1B5A);
    chk("wrap_cursor", {cursor_y, cursor_x}, {5'd0, 5'd0});

    put(2'd1, 16'h1E1F);
    wait_idle("t3a");
    chk("clamp_y30", {cursor_y, cursor_x}, {5'd27, 5'd31});
    put(2'd1, 16'h1F05);
    wait_idle("t3b");
    chk("clamp_y31", {cursor_y, cursor_x}, {5'd27, 5'd5});
    put(2'd0, 16'h000A);
    wait_idle("t3c");
    chk("newline_wrap", {cursor_y, cursor_x}, {5'd0, 5'd0});
    put(2'd0, 16'h0008);
    wait_idle("t3d");
    chk("bs_at_0", {cursor_y, cursor_x}, {5'd0, 5'd0});
    w0 = n_wr;
    put(2'd0, 16'h000D);
    put(2'd0, 16'h0007);
    put(2'd3, 16'h0041);
    wait_idle("t3e");
    chk("ctrl_no_write", 32'(n_wr - w0), 32'd0);
    put(2'd0, 16'h00C1);
    wait_idle("t3f");
    chk("hibyte_q", last_di, 32'h0000_003F);
    put(2'd0, 16'h0008);
    wait_idle("t3g");
    chk("bs_back", {cursor_y, cursor_x}, {5'd0, 5'd0});

    put(2'd2, 16'h0020);
    put(2'd0, 16'h0042);
    for (int k = 0; k < 50; k++) begin
      @(negedge wclk);
      if (char_we != 4'h0) break;
    end
    run = 0;
    while (run < 2000 && char_we == 4'hF && char_di[6:0] == 7'h20) begin
      run++;
      @(negedge wclk);
    end
    chk("clear_run", 32'(run), 32'(NCELL));
    chk("after_fill_we", 32'(char_we), 32'hF);
    chk("after_fill_di", char_di, 32'h0000_0042);
    wait_idle("t4");

    put(2'd2, 16'h002E);
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 16'(8'h31 + i), w);
      wsum += w;
    end
    chk("first8_nowait", 32'(wsum), 32'd0);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    push(2'd0, 16'h0039, w);
    chk("ninth_waited", 32'(w > 100), 32'd1);
    wait_idle("t5");
    chk("ninth_di", last_di, 32'h0008_0039);

    put(2'd2, 16'h0023);
    put(2'd0, 16'h0051);
    put(2'd0, 16'h0052);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge wclk);
      if (char_we != 4'h0) cnt++;
      if (cnt == 100) break;
    end
    chk("fill_seen_100", 32'(cnt), 32'd100);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(char_we), 32'd0);
    chk("abort_di", char_di, 32'd0);
    chk("abort_cursor", {cursor_y, cursor_x}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge wclk);
    @(posedge wclk);
    #1;
    reset = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    w0 = n_wr;
    repeat (950) @(negedge wclk);
    chk("abort_no_writes", 32'(n_wr - w0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_cursor_end", {cursor_y, cursor_x}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
